// File: rtl/width_downsizer.sv
// Splits each IN_W = OUT_W*RATIO word into RATIO OUT_W-bit slices, LSB slice first.
// Optional out_last port is enabled by defining WIDTH_DOWNSIZER_LAST_EN.
module width_downsizer #(
    parameter int OUT_W = 2,
    parameter int RATIO = 2,
    localparam int IN_W = OUT_W * RATIO
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
`ifdef WIDTH_DOWNSIZER_LAST_EN
    ,
    output logic             out_last
`endif
);

    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        BUSY  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IN_W-1:0]   word_q, word_d;
    logic [OUT_W-1:0]  out_data_q, out_data_d;

    logic is_last;
    logic in_xfer;
    logic out_xfer;

    assign is_last  = (idx_q == LAST_IDX);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            idx_q      <= '0;
            word_q     <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
            out_data_q <= out_data_d;
        end
    end

    // Slice is selected from the next-state word/index so out_data is a pure register output.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d = BUSY;
                    idx_d   = '0;
                    word_d  = in_data;
                end
            end
            BUSY: begin
                if (out_xfer) begin
                    if (!is_last) begin
                        idx_d = idx_q + 1'b1;
                    end else if (in_xfer) begin
                        idx_d  = '0;
                        word_d = in_data;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: begin
                state_d = EMPTY;
                idx_d   = '0;
            end
        endcase
        out_data_d = word_d[OUT_W*int'(idx_d) +: OUT_W];
    end

    // in_ready is gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        out_valid = (state_q == BUSY);
        in_ready  = rst_n && ((state_q == EMPTY) ||
                              ((state_q == BUSY) && is_last && out_ready));
        out_data  = out_data_q;
`ifdef WIDTH_DOWNSIZER_LAST_EN
        out_last  = (state_q == BUSY) && is_last;
`endif
    end

endmodule

// File: tb/tb_width_downsizer.sv
// Directed bench for width_downsizer: a 2x2 instance driven from a cycle table and
// a 3x4 instance driven by a hand-written sequence.
module tb_width_downsizer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       a_iv, a_ir, a_ov, a_ordy;
    logic [3:0] a_id;
    logic [1:0] a_od;

    logic        b_iv, b_ir, b_ov, b_ordy;
    logic [11:0] b_id;
    logic [2:0]  b_od;

`ifdef WIDTH_DOWNSIZER_LAST_EN
    logic a_last, b_last;
`endif

    width_downsizer #(.OUT_W(2), .RATIO(2)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_iv),
        .in_ready  (a_ir),
        .in_data   (a_id),
        .out_valid (a_ov),
        .out_ready (a_ordy),
        .out_data  (a_od)
`ifdef WIDTH_DOWNSIZER_LAST_EN
        ,
        .out_last  (a_last)
`endif
    );

    width_downsizer #(.OUT_W(3), .RATIO(4)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_iv),
        .in_ready  (b_ir),
        .in_data   (b_id),
        .out_valid (b_ov),
        .out_ready (b_ordy),
        .out_data  (b_od)
`ifdef WIDTH_DOWNSIZER_LAST_EN
        ,
        .out_last  (b_last)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One row per clock: inputs driven for that cycle and the outputs expected before its edge.
    typedef struct {
        logic       rst_n;
        logic       iv;
        logic [3:0] id;
        logic       ordy;
        logic       ov;
        logic [1:0] od;
        logic       chk_od;
        logic       ir;
        logic       last;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl [NV];

    initial begin
        //         rst   iv    id    ordy  ov    od     chk   ir    last
        tbl[0]  = '{1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 4'hB, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 4'hA, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 4'h5, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 4'h5, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 4'hC, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 4'hF, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 4'h3, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b1};
        tbl[15] = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 1'b1};
        tbl[16] = '{1'b1, 1'b1, 4'h9, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0};
        tbl[17] = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 1'b1, 4'hE, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1};
        tbl[19] = '{1'b1, 1'b1, 4'h6, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0};
        tbl[20] = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0};
        tbl[21] = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1};
        tbl[22] = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0};

        rst_n  = 1'b0;
        a_iv   = 1'b0;
        a_id   = 4'h0;
        a_ordy = 1'b0;
        b_iv   = 1'b0;
        b_id   = 12'h0;
        b_ordy = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst_n  = tbl[i].rst_n;
            a_iv   = tbl[i].iv;
            a_id   = tbl[i].id;
            a_ordy = tbl[i].ordy;
            #1;
            check($sformatf("a_out_valid[%0d]", i), 32'(a_ov), 32'(tbl[i].ov));
            check($sformatf("a_in_ready[%0d]", i), 32'(a_ir), 32'(tbl[i].ir));
            if (tbl[i].chk_od)
                check($sformatf("a_out_data[%0d]", i), 32'(a_od), 32'(tbl[i].od));
`ifdef WIDTH_DOWNSIZER_LAST_EN
            check($sformatf("a_out_last[%0d]", i), 32'(a_last), 32'(tbl[i].last));
`endif
        end

        // 12'hFA5 split in 3-bit slices LSB first: [2:0]=5, [5:3]=4, [8:6]=6, [11:9]=7.
        @(negedge clk);
        b_iv   = 1'b1;
        b_id   = 12'hFA5;
        b_ordy = 1'b1;
        #1;
        check("b_in_ready_empty", 32'(b_ir), 32'd1);
        check("b_out_valid_empty", 32'(b_ov), 32'd0);

        @(negedge clk);
        b_iv = 1'b0;
        b_id = 12'h000;
        #1;
        check("b_slice0", 32'(b_od), 32'd5);
        check("b_valid0", 32'(b_ov), 32'd1);
        check("b_in_ready0", 32'(b_ir), 32'd0);
`ifdef WIDTH_DOWNSIZER_LAST_EN
        check("b_last0", 32'(b_last), 32'd0);
`endif
        @(negedge clk);
        #1;
        check("b_slice1", 32'(b_od), 32'd4);
`ifdef WIDTH_DOWNSIZER_LAST_EN
        check("b_last1", 32'(b_last), 32'd0);
`endif
        @(negedge clk);
        #1;
        check("b_slice2", 32'(b_od), 32'd6);
        check("b_in_ready2", 32'(b_ir), 32'd0);
`ifdef WIDTH_DOWNSIZER_LAST_EN
        check("b_last2", 32'(b_last), 32'd0);
`endif
        @(negedge clk);
        b_ordy = 1'b0;
        #1;
        check("b_slice3_held", 32'(b_od), 32'd7);
        check("b_in_ready3_held", 32'(b_ir), 32'd0);
`ifdef WIDTH_DOWNSIZER_LAST_EN
        check("b_last3_held", 32'(b_last), 32'd1);
`endif
        @(negedge clk);
        b_ordy = 1'b1;
        #1;
        check("b_slice3", 32'(b_od), 32'd7);
        check("b_valid3", 32'(b_ov), 32'd1);
        check("b_in_ready3", 32'(b_ir), 32'd1);
`ifdef WIDTH_DOWNSIZER_LAST_EN
        check("b_last3", 32'(b_last), 32'd1);
`endif
        @(negedge clk);
        #1;
        check("b_valid_done", 32'(b_ov), 32'd0);
        check("b_in_ready_done", 32'(b_ir), 32'd1);
`ifdef WIDTH_DOWNSIZER_LAST_EN
        check("b_last_done", 32'(b_last), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
